// File: rtl/arb_pkg.sv
// Shared definitions for the two-input round-robin arbiter and its mux.
//   SEL_A / SEL_B   : select encoding shared with mux_2x1 (0 = A, 1 = B)
//   grant_t         : which source owns the current grant
//   DATA_W_DEFAULT  : default channel data width
package arb_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  localparam int DATA_W_DEFAULT = 8;

endpackage

// File: rtl/mux_2x1.sv
// Two-input combinational word multiplexer.
//   a, b : candidate words
//   sel  : SEL_A picks a, SEL_B picks b
//   y    : selected word
module mux_2x1
  import arb_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = (sel == SEL_B) ? b : a;

endmodule

// File: rtl/arb_rr_2x1.sv
// Two-input round-robin arbiter with a registered valid/ready output stage.
// Picks at most one source per cycle, steers its word through mux_2x1 and
// registers it into y_data together with the source index on sel.
//   clk, rst_n          : clock, asynchronous active-low reset
//   a_data/a_valid/a_ready : source A channel
//   b_data/b_valid/b_ready : source B channel
//   y_data/y_valid/y_ready : registered output channel
//   sel                 : source of the word held in y_data (0 = A, 1 = B)
// BURST_MAX bounds consecutive contested grants to one source (1..15).
module arb_rr_2x1
  import arb_pkg::*;
#(
  parameter int WIDTH     = DATA_W_DEFAULT,
  parameter int BURST_MAX = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel
);

  localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

  grant_t           last_grant;
  logic [3:0]       burst_cnt;
  logic             load_en;
  logic             grant_vld;
  grant_t           grant;
  logic             other_valid;
  logic [WIDTH-1:0] mux_y;

  function automatic logic [3:0] burst_sat_inc(input logic [3:0] cnt);
    if (cnt >= BURST_MAX_C) return BURST_MAX_C;
    else return cnt + 4'd1;
  endfunction

  // ---- grant stage (combinational) ----
  assign load_en = !y_valid || y_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant     = GRANT_A;
    if (load_en) begin
      if (a_valid && b_valid) begin
        grant_vld = 1'b1;
        // burst_cnt == 0 only right after reset: no streak exists yet, so
        // rotate away from the reset value of last_grant (A wins first).
        if ((burst_cnt != 4'd0) && (burst_cnt < BURST_MAX_C))
          grant = last_grant;
        else
          grant = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
      end else if (a_valid) begin
        grant_vld = 1'b1;
        grant     = GRANT_A;
      end else if (b_valid) begin
        grant_vld = 1'b1;
        grant     = GRANT_B;
      end
    end
  end

  // Readies are gated by rst_n: during reset y_valid is 0, so load_en alone
  // would otherwise advertise acceptance.
  assign a_ready = rst_n && grant_vld && (grant == GRANT_A);
  assign b_ready = rst_n && grant_vld && (grant == GRANT_B);

  assign other_valid = (grant == GRANT_A) ? b_valid : a_valid;

  mux_2x1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a  (a_data),
    .b  (b_data),
    .sel(grant),
    .y  (mux_y)
  );

  // ---- output register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid    <= 1'b0;
      y_data     <= '0;
      sel        <= SEL_A;
      last_grant <= GRANT_B;
      burst_cnt  <= 4'd0;
    end else begin
      if (grant_vld) begin
        y_data     <= mux_y;
        sel        <= grant;
        y_valid    <= 1'b1;
        last_grant <= grant;
        if ((grant == last_grant) && other_valid)
          burst_cnt <= burst_sat_inc(burst_cnt);
        else
          burst_cnt <= 4'd1;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_rr_2x1.sv
module tb_arb_rr_2x1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] a_data = 8'h00;
  logic [7:0] b_data = 8'h00;
  logic       a_valid = 1'b0;
  logic       b_valid = 1'b0;
  logic       y_ready = 1'b0;

  logic       a_rdy0, b_rdy0, y_vld0, sel0;
  logic       a_rdy1, b_rdy1, y_vld1, sel1;
  logic [7:0] y_d0, y_d1;

  int total = 0;
  int passed = 0;

  // reference model state, index 0: BURST_MAX=1, index 1: BURST_MAX=3
  int bm[2] = '{1, 3};
  int m_last[2];
  int m_streak[2];
  int m_yv[2];
  int m_yd[2];
  int m_sel[2];
  int n_last[2], n_streak[2], n_yv[2], n_yd[2], n_sel[2];

  always #5 clk = ~clk;

  arb_rr_2x1 #(.WIDTH(8), .BURST_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_rdy0),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_rdy0),
    .y_data(y_d0), .y_valid(y_vld0), .y_ready(y_ready), .sel(sel0)
  );

  arb_rr_2x1 #(.WIDTH(8), .BURST_MAX(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_rdy1),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_rdy1),
    .y_data(y_d1), .y_valid(y_vld1), .y_ready(y_ready), .sel(sel1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_last[i] = 1; m_streak[i] = 0;
      m_yv[i] = 0; m_yd[i] = 0; m_sel[i] = 0;
    end
  endtask

  function automatic logic [7:0] g_yd(int i);  return (i == 0) ? y_d0 : y_d1;     endfunction
  function automatic logic g_yv(int i);        return (i == 0) ? y_vld0 : y_vld1; endfunction
  function automatic logic g_sel(int i);       return (i == 0) ? sel0 : sel1;     endfunction
  function automatic logic g_ar(int i);        return (i == 0) ? a_rdy0 : a_rdy1; endfunction
  function automatic logic g_br(int i);        return (i == 0) ? b_rdy0 : b_rdy1; endfunction

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_yvalid_d%0d", tag, i), 32'(g_yv(i)), 32'(m_yv[i]));
      chk($sformatf("%s_ydata_d%0d", tag, i), 32'(g_yd(i)), 32'(m_yd[i]));
      chk($sformatf("%s_sel_d%0d", tag, i), 32'(g_sel(i)), 32'(m_sel[i]));
    end
  endtask

  // One clock: check readies against the model, advance the model across the
  // edge, then check the registered outputs.
  task automatic cycle(input string tag);
    #1;
    for (int i = 0; i < 2; i++) begin
      int ga, gb, pick, other;
      ga = 0; gb = 0; pick = -1;
      n_last[i] = m_last[i]; n_streak[i] = m_streak[i];
      n_yv[i] = m_yv[i]; n_yd[i] = m_yd[i]; n_sel[i] = m_sel[i];
      if (rst_n && (m_yv[i] == 0 || y_ready)) begin
        if (a_valid && b_valid) begin
          if (m_streak[i] > 0 && m_streak[i] < bm[i]) pick = m_last[i];
          else pick = 1 - m_last[i];
        end else if (a_valid) pick = 0;
        else if (b_valid) pick = 1;
      end
      ga = (pick == 0); gb = (pick == 1);
      chk($sformatf("%s_aready_d%0d", tag, i), 32'(g_ar(i)), 32'(ga));
      chk($sformatf("%s_bready_d%0d", tag, i), 32'(g_br(i)), 32'(gb));
      if (rst_n) begin
        if (pick >= 0) begin
          other = (pick == 0) ? b_valid : a_valid;
          n_yd[i] = (pick == 0) ? a_data : b_data;
          n_sel[i] = pick;
          n_yv[i] = 1;
          if (pick == m_last[i] && other != 0)
            n_streak[i] = (m_streak[i] + 1 > bm[i]) ? bm[i] : m_streak[i] + 1;
          else
            n_streak[i] = 1;
          n_last[i] = pick;
        end else if (y_ready) begin
          n_yv[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_last[i] = n_last[i]; m_streak[i] = n_streak[i];
      m_yv[i] = n_yv[i]; m_yd[i] = n_yd[i]; m_sel[i] = n_sel[i];
    end
    check_outputs(tag);
  endtask

  initial begin
    int sel1_exp[7];
    int sel3_exp[7];
    sel1_exp = '{0, 1, 0, 1, 0, 1, 0};
    sel3_exp = '{0, 0, 0, 1, 1, 1, 0};
    model_reset();

    // Reset with both sources valid
    a_data = 8'h55; b_data = 8'hAA; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_outputs("reset_async");
    cycle("in_reset");
    cycle("in_reset2");
    rst_n = 1'b1;

    // Contested stream: alternation vs bursts of 3
    for (int k = 0; k < 7; k++) begin
      cycle("contested");
      chk($sformatf("alt_sel_%0d", k), 32'(sel0), 32'(sel1_exp[k]));
      chk($sformatf("alt_data_%0d", k), 32'(y_d0), (sel1_exp[k] == 0) ? 32'h55 : 32'hAA);
      chk($sformatf("burst3_sel_%0d", k), 32'(sel1), 32'(sel3_exp[k]));
    end

    // Only B valid
    a_valid = 1'b0; b_data = 8'h3C;
    for (int k = 0; k < 3; k++) begin
      cycle("only_b");
      chk("only_b_sel", 32'(sel0), 32'd1);
      chk("only_b_data", 32'(y_d0), 32'h3C);
    end

    // Backpressure after one A word
    a_valid = 1'b1; b_data = 8'hAA;
    #1 rst_n = 1'b0; model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    cycle("bp_load");
    chk("bp_first", 32'(y_d0), 32'h55);
    y_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle("bp_hold");
      chk("bp_hold_data", 32'(y_d0), 32'h55);
      chk("bp_hold_valid", 32'(y_vld0), 32'd1);
    end
    y_ready = 1'b1;
    cycle("bp_release");
    chk("bp_next_data", 32'(y_d0), 32'hAA);
    chk("bp_next_sel", 32'(sel0), 32'd1);

    // Mid-stream reset: y_valid must fall without a clock edge
    cycle("pre_rst");
    rst_n = 1'b0;
    #1;
    chk("midrst_yvalid_d0", 32'(y_vld0), 32'd0);
    chk("midrst_yvalid_d1", 32'(y_vld1), 32'd0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    cycle("post_rst");
    chk("post_rst_sel", 32'(sel0), 32'd0);
    chk("post_rst_data", 32'(y_d0), 32'h55);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      a_valid = 1'($urandom_range(3) != 0);
      b_valid = 1'($urandom_range(3) != 0);
      a_data  = 8'($urandom);
      b_data  = 8'($urandom);
      y_ready = 1'($urandom_range(3) != 0);
      if ($urandom_range(99) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rand_rst_yvalid_d0", 32'(y_vld0), 32'd0);
        chk("rand_rst_yvalid_d1", 32'(y_vld1), 32'd0);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
      end
      cycle("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
